wb_port_arbiter: RTL and testbench

//  Shares the single regfile write port (wen/wa/wd) between two requesters:
//  - the in-order writeback stage (pipe)
//  - the multi-cycle multiply/divide unit (mdu)

---
 rtl/wb_port_arbiter.sv | 109 ++++++++++
 tb/tb_wb_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the writeback pipe and the MDU, and forwards
// pipe CSR writes. Pipe has fixed priority unless the MDU has been refused too long.
//
// state    | meaning
// PIPE_PRI | pipe wins when both are valid; MDU refusals are counted
// MDU_PRI  | MDU waited STARVE_MAX refusals and wins this cycle
module wb_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    output logic        pipe_ready,
    input  logic [4:0]  pipe_wa,
    input  logic [63:0] pipe_wd,
    input  logic        pipe_csr_wen,
    input  logic [11:0] pipe_csr_wa,
    input  logic [63:0] pipe_csr_wd,
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_wa,
    input  logic [63:0] mdu_wd,
    output logic        wen,
    output logic [4:0]  wa,
    output logic [63:0] wd,
    output logic        csr_wen,
    output logic [11:0] csr_wa,
    output logic [63:0] csr_wd
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic {PIPE_PRI, MDU_PRI} state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          grant_pipe;
    logic          grant_mdu;

    // Readies are held low while reset is asserted so nothing is consumed then.
    always_comb begin
        pipe_ready = 1'b0;
        mdu_ready  = 1'b0;
        if (reset) begin
            if (state == MDU_PRI) begin
                mdu_ready  = mdu_valid;
                pipe_ready = pipe_valid && !mdu_valid;
            end else begin
                pipe_ready = pipe_valid;
                mdu_ready  = mdu_valid && !pipe_valid;
            end
        end
    end

    assign grant_pipe = pipe_valid && pipe_ready;
    assign grant_mdu  = mdu_valid && mdu_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PIPE_PRI;
            starve_cnt <= '0;
            wen        <= 1'b0;
            wa         <= '0;
            wd         <= '0;
            csr_wen    <= 1'b0;
            csr_wa     <= '0;
            csr_wd     <= '0;
        end else begin
            // x0 is never written, but the beat is still consumed.
            wen     <= (grant_pipe && (pipe_wa != 5'd0)) || (grant_mdu && (mdu_wa != 5'd0));
            csr_wen <= grant_pipe && pipe_csr_wen;
            if (grant_pipe) begin
                wa <= pipe_wa;
                wd <= pipe_wd;
                if (pipe_csr_wen) begin
                    csr_wa <= pipe_csr_wa;
                    csr_wd <= pipe_csr_wd;
                end
            end else if (grant_mdu) begin
                wa <= mdu_wa;
                wd <= mdu_wd;
            end

            unique case (state)
                PIPE_PRI: begin
                    if (mdu_valid && !mdu_ready) begin
                        if (starve_cnt == CW'(STARVE_MAX - 1)) begin
                            state      <= MDU_PRI;
                            starve_cnt <= '0;
                        end else begin
                            starve_cnt <= starve_cnt + CW'(1);
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                MDU_PRI: begin
                    state      <= PIPE_PRI;
                    starve_cnt <= '0;
                end
                default: begin
                    state      <= PIPE_PRI;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized bench for wb_port_arbiter against a refusal-counting reference model.
module tb_wb_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid, pipe_ready, pipe_csr_wen;
    logic [4:0]  pipe_wa;
    logic [63:0] pipe_wd, pipe_csr_wd;
    logic [11:0] pipe_csr_wa;
    logic        mdu_valid, mdu_ready;
    logic [4:0]  mdu_wa;
    logic [63:0] mdu_wd;
    logic        wen, csr_wen;
    logic [4:0]  wa;
    logic [63:0] wd, csr_wd;
    logic [11:0] csr_wa;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_refused;
    logic        e_pready, e_mready, m_gp, m_gm;
    logic        e_wen, e_csr_wen;
    logic [4:0]  e_wa;
    logic [63:0] e_wd, e_csr_wd;
    logic [11:0] e_csr_wa;

    wb_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_ready(pipe_ready), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .pipe_csr_wen(pipe_csr_wen), .pipe_csr_wa(pipe_csr_wa), .pipe_csr_wd(pipe_csr_wd),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd),
        .wen(wen), .wa(wa), .wd(wd), .csr_wen(csr_wen), .csr_wa(csr_wa), .csr_wd(csr_wd)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_refused = 0;
        e_wen = 0; e_wa = 0; e_wd = 0;
        e_csr_wen = 0; e_csr_wa = 0; e_csr_wd = 0;
        m_gp = 0; m_gm = 0;
    endtask

    // The MDU wins when alone, or when it has already been turned away STARVE_MAX times.
    task automatic model_ready();
        bit mdu_wins;
        mdu_wins = mdu_valid && (!pipe_valid || m_refused >= STARVE_MAX);
        e_mready = mdu_wins;
        e_pready = pipe_valid && !mdu_wins;
    endtask

    task automatic model_clock();
        m_gp = pipe_valid && e_pready;
        m_gm = mdu_valid && e_mready;
        e_wen     = (m_gp && pipe_wa != 0) || (m_gm && mdu_wa != 0);
        e_csr_wen = m_gp && pipe_csr_wen;
        if (m_gp) begin
            e_wa = pipe_wa; e_wd = pipe_wd;
            if (pipe_csr_wen) begin e_csr_wa = pipe_csr_wa; e_csr_wd = pipe_csr_wd; end
        end else if (m_gm) begin
            e_wa = mdu_wa; e_wd = mdu_wd;
        end
        m_refused = (mdu_valid && !m_gm) ? m_refused + 1 : 0;
    endtask

    task automatic pre_edge();
        #2;
        model_ready();
    endtask

    task automatic post_edge();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic new_pipe();
        pipe_wa      = 5'($urandom_range(0, 31));
        pipe_wd      = {$urandom, $urandom};
        pipe_csr_wen = 1'($urandom_range(0, 1));
        pipe_csr_wa  = 12'($urandom);
        pipe_csr_wd  = {$urandom, $urandom};
    endtask

    task automatic new_mdu();
        mdu_wa = 5'($urandom_range(0, 31));
        mdu_wd = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        pipe_valid = 1; mdu_valid = 1;
        new_pipe(); new_mdu();
        #2;
        total++;
        if (pipe_ready !== 1'b0 || mdu_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready got %b%b want 00", pipe_ready, mdu_ready);
        end
        total++;
        if ({wen, csr_wen, wa, wd, csr_wa, csr_wd} !== '0) begin
            bad++; $display("FAIL reset_outputs wen=%b csr_wen=%b wa=%0d wd=%h want all 0", wen, csr_wen, wa, wd);
        end
        @(posedge clk); #1;
        reset = 1;
        model_reset();
        pre_edge();
        total++;
        if (pipe_ready !== 1'b1 || mdu_ready !== 1'b0) begin
            bad++; $display("FAIL reset_first_grant got p=%b m=%b want p=1 m=0", pipe_ready, mdu_ready);
        end
        post_edge();
        pipe_valid = 0; mdu_valid = 0;
        total++;
        if (wen !== e_wen || wa !== e_wa || wd !== e_wd) begin
            bad++; $display("FAIL reset_first_write got %b/%0d/%h want %b/%0d/%h", wen, wa, wd, e_wen, e_wa, e_wd);
        end
    endtask

    task automatic test_pipe_only();
        pipe_valid = 1; pipe_wa = 5; pipe_wd = 64'hDEAD; pipe_csr_wen = 0;
        pre_edge();
        total++;
        if (pipe_ready !== 1'b1 || mdu_ready !== 1'b0) begin
            bad++; $display("FAIL pipe_only_ready got p=%b m=%b want p=1 m=0", pipe_ready, mdu_ready);
        end
        post_edge();
        pipe_valid = 0;
        total++;
        if (wen !== 1'b1 || wa !== 5'd5 || wd !== 64'hDEAD || csr_wen !== 1'b0) begin
            bad++; $display("FAIL pipe_only_write got %b/%0d/%h csr=%b want 1/5/dead csr=0", wen, wa, wd, csr_wen);
        end
        pre_edge();
        post_edge();
        total++;
        if (wen !== 1'b0 || wa !== 5'd5 || wd !== 64'hDEAD) begin
            bad++; $display("FAIL pipe_only_idle got %b/%0d/%h want 0/5/dead", wen, wa, wd);
        end
    endtask

    task automatic test_starve(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            pre_edge();
            total++;
            if (pipe_ready !== e_pready || mdu_ready !== e_mready || mdu_ready !== (i == STARVE_MAX)) begin
                bad++; $display("FAIL %s_grant cyc=%0d got p=%b m=%b want p=%b m=%b", tag, i, pipe_ready, mdu_ready, e_pready, e_mready);
            end
            post_edge();
            total++;
            if (wen !== e_wen || wa !== e_wa || wd !== e_wd || csr_wen !== e_csr_wen) begin
                bad++; $display("FAIL %s_write cyc=%0d got %b/%0d/%h want %b/%0d/%h", tag, i, wen, wa, wd, e_wen, e_wa, e_wd);
            end
            if (m_gm) mdu_valid = 0;
            if (m_gp) new_pipe();
        end
        pipe_valid = 0; mdu_valid = 0;
    endtask

    task automatic test_x0_csr();
        pipe_valid = 1; pipe_wa = 0; pipe_wd = 64'h1234;
        pipe_csr_wen = 1; pipe_csr_wa = 12'h300; pipe_csr_wd = 64'h8;
        pre_edge();
        post_edge();
        pipe_valid = 0;
        total++;
        if (wen !== 1'b0 || csr_wen !== 1'b1 || csr_wa !== 12'h300 || csr_wd !== 64'h8) begin
            bad++; $display("FAIL x0_csr got wen=%b csr=%b/%h/%h want 0/1/300/8", wen, csr_wen, csr_wa, csr_wd);
        end
        pre_edge();
        post_edge();
        total++;
        if (csr_wen !== 1'b0 || csr_wa !== 12'h300 || csr_wd !== 64'h8) begin
            bad++; $display("FAIL x0_csr_hold got csr=%b/%h/%h want 0/300/8", csr_wen, csr_wa, csr_wd);
        end
    endtask

    task automatic test_mdu_only();
        mdu_valid = 1; mdu_wa = 10; mdu_wd = 64'd42;
        pre_edge();
        total++;
        if (mdu_ready !== 1'b1 || pipe_ready !== 1'b0) begin
            bad++; $display("FAIL mdu_only_ready got p=%b m=%b want p=0 m=1", pipe_ready, mdu_ready);
        end
        post_edge();
        mdu_valid = 0;
        total++;
        if (wen !== 1'b1 || wa !== 5'd10 || wd !== 64'd42 || csr_wen !== 1'b0) begin
            bad++; $display("FAIL mdu_only_write got %b/%0d/%0d csr=%b want 1/10/42 csr=0", wen, wa, wd, csr_wen);
        end
    endtask

    task automatic test_reset_mid();
        pipe_valid = 1; mdu_valid = 1; new_pipe(); new_mdu(); pipe_wa = 3;
        for (int i = 0; i < 2; i++) begin
            pre_edge(); post_edge(); new_pipe(); pipe_wa = 3;
        end
        pre_edge();
        total++;
        if (pipe_ready !== 1'b1) begin
            bad++; $display("FAIL reset_mid_ready got %b want 1", pipe_ready);
        end
        reset = 0;
        model_reset();
        @(posedge clk); #1;
        total++;
        if (wen !== 1'b0 || csr_wen !== 1'b0) begin
            bad++; $display("FAIL reset_mid_dropped got wen=%b csr_wen=%b want 0 0", wen, csr_wen);
        end
        reset = 1;
        test_starve("reset_mid", STARVE_MAX + 2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (!pipe_valid) begin pipe_valid = 1'($urandom_range(0, 2) != 0); new_pipe(); end
            if (!mdu_valid)  begin mdu_valid  = 1'($urandom_range(0, 2) == 0); new_mdu(); end
            pre_edge();
            total++;
            if (pipe_ready !== e_pready || mdu_ready !== e_mready || (pipe_ready && mdu_ready)) begin
                bad++; $display("FAIL rand_ready cyc=%0d got p=%b m=%b want p=%b m=%b", i, pipe_ready, mdu_ready, e_pready, e_mready);
            end
            post_edge();
            total++;
            if (wen !== e_wen || wa !== e_wa || wd !== e_wd || csr_wen !== e_csr_wen ||
                csr_wa !== e_csr_wa || csr_wd !== e_csr_wd) begin
                bad++; $display("FAIL rand_out cyc=%0d got %b/%0d/%h csr %b/%h want %b/%0d/%h csr %b/%h",
                                i, wen, wa, wd, csr_wen, csr_wa, e_wen, e_wa, e_wd, e_csr_wen, e_csr_wa);
            end
            if (m_gp) pipe_valid = 0;
            if (m_gm) mdu_valid = 0;
        end
        pipe_valid = 0; mdu_valid = 0;
    endtask

    initial begin
        reset = 0;
        pipe_valid = 0; mdu_valid = 0;
        pipe_wa = 0; pipe_wd = 0; pipe_csr_wen = 0; pipe_csr_wa = 0; pipe_csr_wd = 0;
        mdu_wa = 0; mdu_wd = 0;
        model_reset();
        test_reset();
        test_pipe_only();
        pipe_valid = 1; mdu_valid = 1; new_pipe(); new_mdu();
        test_starve("starve", STARVE_MAX + 2);
        test_x0_csr();
        test_mdu_only();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
